// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter onto a single-outstanding unified memory
//
// Purpose: serialises instruction-fetch and load/store requests onto one
// memory port. Only one transaction is in flight at a time (IDLE -> REQ -> RSP).
// Data normally wins arbitration. After STARVE_LIMIT consecutive contested data
// wins, the instruction port is forced to win.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   i_req, i_addr                      instruction fetch request
//   i_gnt, i_rvalid, i_rdata           instruction grant / response
//   d_req, d_we, d_addr, d_wdata       load/store request
//   d_gnt, d_rvalid, d_rdata           data grant / response
//   m_req, m_we, m_addr, m_wdata       unified memory request
//   m_gnt, m_rvalid, m_rdata           unified memory grant / response
//   busy                               high whenever a transaction is in progress

module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state, state_nx;
   logic        owner_i;      // 1 = instruction port owns the transaction
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [3:0]  starve_cnt;
   logic        pick_i;
   logic        take;

   // The instruction port wins when it is alone, or when it has been passed
   // over by data STARVE_LIMIT times in a row.
   always_comb begin
      pick_i = i_req & (~d_req | (starve_cnt == LIMIT));
      take   = (state == IDLE) & (i_req | d_req);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner_i    <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         we_q       <= 1'b0;
         starve_cnt <= 4'h0;
      end else begin
         state <= state_nx;
         if (take) begin
            owner_i <= pick_i;
            addr_q  <= pick_i ? i_addr : d_addr;
            wdata_q <= pick_i ? 32'h0 : d_wdata;
            we_q    <= pick_i ? 1'b0 : d_we;
            if (pick_i)
               starve_cnt <= 4'h0;
            else if (i_req && starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + 4'h1;  // contested data win
         end
      end
   end

   always_comb begin
      state_nx = state;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      m_req    = 1'b0;
      case (state)
         IDLE: begin
            if (i_req || d_req)
               state_nx = REQ;
         end
         REQ: begin
            m_req = 1'b1;
            i_gnt = m_gnt & owner_i;
            d_gnt = m_gnt & ~owner_i;
            if (m_gnt)
               state_nx = RSP;
         end
         RSP: begin
            i_rvalid = m_rvalid & owner_i;
            d_rvalid = m_rvalid & ~owner_i;
            if (m_rvalid)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request fields come straight from the latch registers so they stay
   // stable while waiting for m_gnt and hold their value between transactions.
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign m_we    = we_q & ~owner_i;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'h0;
   logic        i_gnt, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic        m_gnt = 1'b0, m_rvalid = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   logic        busy;

   int tests = 0;
   int fails = 0;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr, dwe;
      logic [31:0] da, dwd;
      logic        mg, mv;
      logic [31:0] mrd;
      logic        e_mreq, e_mwe;
      logic [31:0] e_maddr, e_mwdata;
      logic        e_ig, e_dg, e_iv, e_dv, e_busy;
   } vec_t;

   typedef struct {
      logic        is_i;
      logic [31:0] rdata;
   } rsp_t;

   vec_t vecs[16];
   logic own_q[$];     // expected grant order, 1 = instruction port
   rsp_t rsp_q[$];     // expected responses, pushed at grant

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic ir, input logic [31:0] ia,
      input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
      input logic mg, input logic mv, input logic [31:0] mrd,
      input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
      input logic eig, input logic edg, input logic eiv, input logic edv, input logic eb);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
      v.mg = mg; v.mv = mv; v.mrd = mrd;
      v.e_mreq = emr; v.e_mwe = emw; v.e_maddr = ema; v.e_mwdata = emd;
      v.e_ig = eig; v.e_dg = edg; v.e_iv = eiv; v.e_dv = edv; v.e_busy = eb;
      return v;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},     busy,     0);
      chk({tag, "_m_req"},    m_req,    0);
      chk({tag, "_i_gnt"},    i_gnt,    0);
      chk({tag, "_d_gnt"},    d_gnt,    0);
      chk({tag, "_i_rvalid"}, i_rvalid, 0);
      chk({tag, "_d_rvalid"}, d_rvalid, 0);
   endtask

   // Free-running zero-wait memory: grant and respond every cycle. The
   // scoreboard checks grant order, port exclusivity and response routing.
   task automatic run_sb(input int n_grants, input int max_cyc);
      int   grants = 0;
      int   cyc = 0;
      logic exp_i;
      rsp_t r;
      while ((grants < n_grants || rsp_q.size() > 0) && cyc < max_cyc) begin
         @(posedge clk); #1;
         m_gnt = 1'b1;
         m_rvalid = 1'b1;
         m_rdata = m_addr ^ K;
         if (grants >= n_grants) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         @(negedge clk);
         if (i_gnt || d_gnt) begin
            chk("gnt_exclusive", {31'h0, i_gnt & d_gnt}, 0);
            if (own_q.size() == 0) begin
               chk("unexpected_grant", {31'h0, i_gnt | d_gnt}, 0);
            end else begin
               exp_i = own_q.pop_front();
               chk("grant_order_i", {31'h0, i_gnt}, {31'h0, exp_i});
               r.is_i = exp_i;
               r.rdata = (exp_i ? i_addr : d_addr) ^ K;
               rsp_q.push_back(r);
               grants++;
            end
         end
         if (i_rvalid || d_rvalid) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_rvalid", {31'h0, i_rvalid | d_rvalid}, 0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_port_i", {31'h0, i_rvalid}, {31'h0, r.is_i});
               chk("rsp_data", r.is_i ? i_rdata : d_rdata, r.rdata);
            end
         end
         cyc++;
      end
      if (grants < n_grants || rsp_q.size() > 0)
         chk("sb_timeout", grants, n_grants);
      @(posedge clk); #1;
      m_gnt = 1'b0;
      m_rvalid = 1'b0;
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        ir ia            dr we da            dwd            mg mv mrd             mreq we addr          wdata          ig dg iv dv busy
      vecs[0]  = mk(1, 32'h10,   0, 0, 32'h0,   32'h0,         1, 0, 32'h0,           0, 0, 32'h0,   32'h0,         0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 32'h10,   0, 0, 32'h0,   32'h0,         1, 0, 32'h0,           1, 0, 32'h10,  32'h0,         1, 0, 0, 0, 1);
      vecs[2]  = mk(0, 32'h10,   0, 0, 32'h0,   32'h0,         1, 1, 32'h0050_0093,   0, 0, 32'h10,  32'h0,         0, 0, 1, 0, 1);
      vecs[3]  = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         1, 0, 32'h0,           0, 0, 32'h10,  32'h0,         0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 32'h0,    1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0,           0, 0, 32'h10,  32'h0,         0, 0, 0, 0, 0);
      vecs[5]  = mk(0, 32'h0,    1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0,           1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
      vecs[6]  = mk(0, 32'h0,    1, 1, 32'h200, 32'h1234_5678, 0, 0, 32'h0,           1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
      vecs[7]  = mk(0, 32'h0,    1, 1, 32'h200, 32'h1234_5678, 0, 1, 32'h7777_7777,   1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
      vecs[8]  = mk(0, 32'h0,    1, 1, 32'h200, 32'h1234_5678, 1, 0, 32'h0,           1, 1, 32'h100, 32'hDEAD_BEEF, 0, 1, 0, 0, 1);
      vecs[9]  = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         1, 0, 32'h0,           0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
      vecs[10] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         0, 1, 32'hCAFE_0001,   0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 1, 1);
      vecs[11] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         0, 1, 32'h5555_5555,   0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      vecs[12] = mk(0, 32'h0,    1, 0, 32'h40,  32'h0,         0, 0, 32'h0,           0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      vecs[13] = mk(0, 32'h0,    1, 0, 32'h40,  32'h0,         1, 0, 32'h0,           1, 0, 32'h40,  32'h0,         0, 1, 0, 0, 1);
      vecs[14] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         0, 1, 32'h1122_3344,   0, 0, 32'h40,  32'h0,         0, 0, 0, 1, 1);
      vecs[15] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         0, 0, 32'h0,           0, 0, 32'h40,  32'h0,         0, 0, 0, 0, 0);

      // Reset state, checked while reset is still asserted.
      #1 reset = 1'b1;
      #1;
      check_idle_outputs("reset");
      chk("reset_m_addr",  m_addr,  0);
      chk("reset_m_wdata", m_wdata, 0);
      chk("reset_m_we",    m_we,    0);
      @(posedge clk); #1 reset = 1'b0;

      // Cycle-by-cycle vectors: lone fetch, stalled store with address change
      // and stray m_gnt/m_rvalid, then a load.
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         i_req = vecs[k].ir; i_addr = vecs[k].ia;
         d_req = vecs[k].dr; d_we = vecs[k].dwe; d_addr = vecs[k].da; d_wdata = vecs[k].dwd;
         m_gnt = vecs[k].mg; m_rvalid = vecs[k].mv; m_rdata = vecs[k].mrd;
         @(negedge clk);
         chk($sformatf("v%0d_m_req", k),    m_req,    vecs[k].e_mreq);
         chk($sformatf("v%0d_m_we", k),     m_we,     vecs[k].e_mwe);
         chk($sformatf("v%0d_m_addr", k),   m_addr,   vecs[k].e_maddr);
         chk($sformatf("v%0d_m_wdata", k),  m_wdata,  vecs[k].e_mwdata);
         chk($sformatf("v%0d_i_gnt", k),    i_gnt,    vecs[k].e_ig);
         chk($sformatf("v%0d_d_gnt", k),    d_gnt,    vecs[k].e_dg);
         chk($sformatf("v%0d_i_rvalid", k), i_rvalid, vecs[k].e_iv);
         chk($sformatf("v%0d_d_rvalid", k), d_rvalid, vecs[k].e_dv);
         chk($sformatf("v%0d_busy", k),     busy,     vecs[k].e_busy);
         chk($sformatf("v%0d_i_rdata", k),  i_rdata,  vecs[k].mrd);
         chk($sformatf("v%0d_d_rdata", k),  d_rdata,  vecs[k].mrd);
      end

      // Both ports requesting continuously: four data wins, then one fetch.
      @(posedge clk); #1;
      m_gnt = 1'b0; m_rvalid = 1'b0;
      i_req = 1'b1; i_addr = 32'h1000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0;
      for (int k = 0; k < 10; k++)
         own_q.push_back((k == 4 || k == 9) ? 1'b1 : 1'b0);
      run_sb(10, 60);

      // Reset in the middle of RSP, with a late memory response.
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h30; m_gnt = 1'b1; m_rvalid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_seq_i_gnt", i_gnt, 1);
      @(posedge clk); #1;
      i_req = 1'b0; m_gnt = 1'b0;
      @(negedge clk);
      chk("rst_seq_in_rsp_busy", busy, 1);
      #2;
      reset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BAD_0BAD;
      #1;
      check_idle_outputs("rst_mid");
      chk("rst_mid_m_addr",  m_addr,  0);
      chk("rst_mid_m_wdata", m_wdata, 0);
      chk("rst_mid_m_we",    m_we,    0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_after1");
      @(posedge clk); #1;
      @(negedge clk);
      check_idle_outputs("rst_after2");
      @(posedge clk); #1;
      m_rvalid = 1'b0;
      i_req = 1'b1; i_addr = 32'h44;
      own_q.push_back(1'b1);
      run_sb(1, 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive data wins before instruction port is forced to win; legal range 1..15.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_req  in  1  instruction-fetch request; held until i_gnt.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_gnt  out  1  fetch accepted by memory.
REQ-007 i_rvalid  out  1  fetch data valid.
REQ-008 i_rdata  out  32  fetched instruction word.
REQ-009 d_req  in  1  load/store request; held with d_we, d_addr and d_wdata until d_gnt.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data address (ALU result).
REQ-012 d_wdata  in  32  store data (rs2).
REQ-013 d_gnt  out  1  data access accepted by memory.
REQ-014 d_rvalid  out  1  load data valid, or store acknowledged.
REQ-015 d_rdata  out  32  load data.
REQ-016 m_req  out  1  request to the unified memory.
REQ-017 m_we  out  1  memory write enable.
REQ-018 m_addr  out  32  memory address.
REQ-019 m_wdata  out  32  memory write data.
REQ-020 m_gnt  in  1  memory accepts m_req this cycle.
REQ-021 m_rvalid  in  1  memory response (read data or write ack).
REQ-022 m_rdata  in  32  memory read data.
REQ-023 busy  out  1  high whenever state is not IDLE.

Function
REQ-024 The FSM SHALL have three states, IDLE, REQ and RSP, with exactly one memory transaction outstanding at any time.
REQ-025 IDLE: if any request is present, pick a winner, latch owner, address, we and wdata into registers, and go to REQ next cycle; with no request, stay in IDLE.
REQ-026 Winner rule: d wins over i, except that i wins when both are requesting and starve_cnt == STARVE_LIMIT; a lone requester always wins.
REQ-027 starve_cnt (4-bit) rules:
  - increments, saturating at STARVE_LIMIT, when both ports request in IDLE and d wins;
  - clears to 0 whenever i wins;
  - otherwise holds.
REQ-028 REQ: m_req = 1, with m_addr, m_we and m_wdata driven from the latched registers; m_we is forced to 0 when owner = i.
REQ-029 REQ with m_gnt = 1: the owner's gnt is high in that same cycle (combinational), and the FSM goes to RSP next cycle; with m_gnt = 0, stay in REQ with all outputs stable.
REQ-030 RSP: the owner's rvalid = m_rvalid and its rdata = m_rdata (combinational pass-through); on m_rvalid the FSM goes to IDLE next cycle.
REQ-031 The non-owner's gnt and rvalid SHALL be 0; both rdata buses SHALL carry m_rdata (valid only when qualified by rvalid).
REQ-032 m_gnt outside REQ and m_rvalid outside RSP SHALL be ignored.
REQ-033 Requester input changes after latching SHALL NOT affect the transaction in flight.
REQ-034 Minimum cost is 3 cycles per transaction (IDLE, REQ, RSP) with zero-wait memory; one request in IDLE at cycle 0 gives m_req at cycle 1.
REQ-035 When m_req = 0, m_addr, m_wdata and m_we SHALL hold their last latched values.

Reset
REQ-036 Reset assertion SHALL immediately force:
  - state = IDLE and starve_cnt = 0;
  - owner, m_addr, m_wdata and m_we = 0;
  - all gnt, rvalid, m_req and busy outputs = 0.
REQ-037 Reset during REQ or RSP SHALL abort the transaction; a memory response arriving after release is ignored, and arbitration resumes from IDLE on the first clock after deassertion.

Verification
REQ-038 Lone i_req with i_addr = 0x0000_0010, m_gnt tied to 1, m_rvalid one cycle after grant with m_rdata = 0x0050_0093 -> m_req at cycle 1, i_gnt at cycle 1, i_rvalid with 0x0050_0093 at cycle 2, busy low at cycle 3.
REQ-039 d_req store with d_addr = 0x100 and d_wdata = 0xDEAD_BEEF, m_gnt held low for 3 cycles -> m_req, m_we = 1, m_addr = 0x100 and m_wdata stable through all wait cycles, then d_gnt on the cycle m_gnt rises.
REQ-040 i_req and d_req held continuously, STARVE_LIMIT = 4 -> grant order d,d,d,d,i,d,d,d,d,i; i_gnt/d_gnt never both high.
REQ-041 m_rvalid pulsed while in IDLE or REQ, and m_gnt pulsed while in RSP -> no rvalid or gnt on either port and no state change.
REQ-042 Reset asserted mid-RSP, then m_rvalid arriving after release -> all outputs 0 immediately; no rvalid to either port; a new i_req is served normally.
REQ-043 d_addr changed while in REQ -> m_addr keeps the latched address until the transaction completes.
